// File: rtl/nw_job_controller_if.sv
// Job/result handshake bundle between the host queue and nw_job_controller.
// master: host side (offers jobs, consumes results); slave: controller side.
interface nw_job_controller_if #(
  parameter int LENGTH = 10,
  parameter int CWIDTH = 2,
  parameter int SWIDTH = 16,
  parameter int IDW    = 4,
  parameter int CNTW   = 16
);
  logic                       job_valid;
  logic                       job_ready;
  logic [LENGTH*CWIDTH-1:0]   job_s1;
  logic [LENGTH*CWIDTH-1:0]   job_s2;
  logic [IDW-1:0]             job_id;

  logic                       res_valid;
  logic                       res_ready;
  logic signed [SWIDTH-1:0]   res_score;
  logic [IDW-1:0]             res_id;
  logic [CNTW-1:0]            res_cycles;
  logic                       res_timeout;

  modport master (
    output job_valid, job_s1, job_s2, job_id, res_ready,
    input  job_ready, res_valid, res_score, res_id,
    input  res_cycles, res_timeout
  );

  modport slave (
    input  job_valid, job_s1, job_s2, job_id, res_ready,
    output job_ready, res_valid, res_score, res_id,
    output res_cycles, res_timeout
  );
endinterface

// File: rtl/nw_job_controller.sv
// Sequencer for one Needleman-Wunsch grid: accept job, clear, run, report.
// Ports: clk/reset (sync, active-high), job_if (job+result handshakes),
// grid_* (grid reset, held strings, score/valid back), busy, jobs_done.
module nw_job_controller #(
  parameter int LENGTH       = 10,
  parameter int CWIDTH       = 2,
  parameter int SWIDTH       = 16,
  parameter int IDW          = 4,
  parameter int CNTW         = 16,
  parameter int CLEAR_CYCLES = 2,
  parameter int TIMEOUT      = 1000
) (
  input  logic                       clk,
  input  logic                       reset,
  nw_job_controller_if.slave         job_if,
  output logic                       grid_reset,
  output logic [LENGTH*CWIDTH-1:0]   grid_s1,
  output logic [LENGTH*CWIDTH-1:0]   grid_s2,
  input  logic signed [SWIDTH-1:0]   grid_score,
  input  logic                       grid_valid,
  output logic                       busy,
  output logic [CNTW-1:0]            jobs_done
);

  localparam int SW = LENGTH * CWIDTH;
  localparam logic [CNTW-1:0] ONE      = CNTW'(1);
  localparam logic [CNTW-1:0] CLR_LAST = CNTW'(CLEAR_CYCLES - 1);
  localparam logic [CNTW-1:0] TO_LAST  = CNTW'(TIMEOUT - 1);
  localparam logic [CNTW-1:0] TO_VAL   = CNTW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [CNTW-1:0]          cnt_q, cnt_d;
  logic [SW-1:0]            s1_q, s1_d;
  logic [SW-1:0]            s2_q, s2_d;
  logic [IDW-1:0]           id_q, id_d;
  logic signed [SWIDTH-1:0] score_q, score_d;
  logic [CNTW-1:0]          cycles_q, cycles_d;
  logic                     tout_q, tout_d;
  logic [CNTW-1:0]          jobs_q, jobs_d;

  // cnt_q is shared: it times the clear phase, then the run phase.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    id_d     = id_q;
    score_d  = score_q;
    cycles_d = cycles_q;
    tout_d   = tout_q;
    jobs_d   = jobs_q;
    unique case (state_q)
      IDLE: begin
        if (job_if.job_valid) begin
          s1_d    = job_if.job_s1;
          s2_d    = job_if.job_s2;
          id_d    = job_if.job_id;
          cnt_d   = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        if (cnt_q == CLR_LAST) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      RUN: begin
        // grid completion beats the timeout boundary
        if (grid_valid) begin
          score_d  = grid_score;
          cycles_d = cnt_q;
          tout_d   = 1'b0;
          state_d  = DONE;
        end else if (cnt_q == TO_LAST) begin
          score_d  = '0;
          cycles_d = TO_VAL;
          tout_d   = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      DONE: begin
        if (job_if.res_ready) begin
          jobs_d  = jobs_q + ONE;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      id_q     <= '0;
      score_q  <= '0;
      cycles_q <= '0;
      tout_q   <= 1'b0;
      jobs_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      id_q     <= id_d;
      score_q  <= score_d;
      cycles_q <= cycles_d;
      tout_q   <= tout_d;
      jobs_q   <= jobs_d;
    end
  end

  // Control outputs decode the state register only.
  assign grid_reset         = (state_q == IDLE) || (state_q == CLEAR);
  assign job_if.job_ready   = (state_q == IDLE);
  assign job_if.res_valid   = (state_q == DONE);
  assign busy               = (state_q != IDLE);

  assign grid_s1            = s1_q;
  assign grid_s2            = s2_q;
  assign job_if.res_score   = score_q;
  assign job_if.res_id      = id_q;
  assign job_if.res_cycles  = cycles_q;
  assign job_if.res_timeout = tout_q;
  assign jobs_done          = jobs_q;

endmodule

// File: tb/tb_nw_job_controller.sv
// Self-checking bench for nw_job_controller with a behavioural grid stub.
// Vector table + scoreboard queue, plus hand-written corner sequences.
module tb_nw_job_controller;

  localparam int L    = 4;
  localparam int CW   = 2;
  localparam int SWD  = 16;
  localparam int IDW  = 4;
  localparam int CNTW = 6;
  localparam int CLR  = 2;
  localparam int TO   = 50;
  localparam int W    = L * CW;
  localparam int WRAP = 1 << CNTW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nw_job_controller_if #(
    .LENGTH(L), .CWIDTH(CW), .SWIDTH(SWD), .IDW(IDW), .CNTW(CNTW)
  ) jif ();

  logic                    grid_reset;
  logic [W-1:0]            grid_s1;
  logic [W-1:0]            grid_s2;
  logic signed [SWD-1:0]   grid_score;
  logic                    grid_valid;
  logic                    busy;
  logic [CNTW-1:0]         jobs_done;

  nw_job_controller #(
    .LENGTH(L), .CWIDTH(CW), .SWIDTH(SWD), .IDW(IDW), .CNTW(CNTW),
    .CLEAR_CYCLES(CLR), .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .job_if     (jif),
    .grid_reset (grid_reset),
    .grid_s1    (grid_s1),
    .grid_s2    (grid_s2),
    .grid_score (grid_score),
    .grid_valid (grid_valid),
    .busy       (busy),
    .jobs_done  (jobs_done)
  );

  // Reference NW score: match +1, mismatch -1, gap -1.
  function automatic int nw_score(input logic [W-1:0] a,
                                  input logic [W-1:0] b);
    int h [0:L][0:L];
    int d, u, f, m;
    for (int i = 0; i <= L; i++) h[i][0] = -i;
    for (int j = 0; j <= L; j++) h[0][j] = -j;
    for (int i = 1; i <= L; i++) begin
      for (int j = 1; j <= L; j++) begin
        d = h[i-1][j-1] +
            ((a[(L-i)*CW +: CW] == b[(L-j)*CW +: CW]) ? 1 : -1);
        u = h[i-1][j] - 1;
        f = h[i][j-1] - 1;
        m = d;
        if (u > m) m = u;
        if (f > m) m = f;
        h[i][j] = m;
      end
    end
    return h[L][L];
  endfunction

  // Grid stub: grid_valid rises stub_lat cycles after grid_reset falls.
  int                    stub_lat = -1;
  logic                  stub_ovr = 1'b0;
  logic signed [SWD-1:0] stub_score = '0;
  int                    rcnt = 0;

  always @(posedge clk) begin
    if (grid_reset) rcnt <= 0;
    else            rcnt <= rcnt + 1;
  end

  assign grid_valid = !grid_reset && (stub_lat >= 0) && (rcnt >= stub_lat);
  assign grid_score = stub_ovr ? stub_score : SWD'(nw_score(grid_s1, grid_s2));

  typedef struct {
    logic [W-1:0]          s1;
    logic [W-1:0]          s2;
    logic [IDW-1:0]        id;
    int                    lat;
    bit                    ovr;
    logic signed [SWD-1:0] gscore;
    logic signed [SWD-1:0] e_score;
    int                    e_cyc;
    bit                    e_to;
  } vec_t;

  typedef struct {
    logic [W-1:0]          s1;
    logic [W-1:0]          s2;
    logic [IDW-1:0]        id;
    logic signed [SWD-1:0] score;
    logic [CNTW-1:0]       cyc;
    logic                  to;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   jd_exp = 0;

  task automatic chk(input string nm, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_ctl"},
        {grid_reset, jif.job_ready, jif.res_valid, busy, jif.res_timeout},
        5'b11000);
    chk({nm, "_score"}, jif.res_score, 0);
    chk({nm, "_id"}, jif.res_id, 0);
    chk({nm, "_cycles"}, jif.res_cycles, 0);
    chk({nm, "_jobs"}, jobs_done, 0);
    chk({nm, "_s"}, {grid_s1, grid_s2}, 0);
  endtask

  // Called at a negedge; returns at the negedge of the first RUN cycle.
  task automatic send(input vec_t v);
    int n;
    int hi;
    exp_t e;
    stub_lat   = v.lat;
    stub_ovr   = v.ovr;
    stub_score = v.gscore;
    n = 0;
    while (!jif.job_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!jif.job_ready) chk("job_ready_wait", 0, 1);
    jif.job_s1    = v.s1;
    jif.job_s2    = v.s2;
    jif.job_id    = v.id;
    jif.job_valid = 1'b1;
    e.s1 = v.s1; e.s2 = v.s2; e.id = v.id;
    e.score = v.e_score; e.cyc = CNTW'(v.e_cyc); e.to = v.e_to;
    sb.push_back(e);
    @(posedge clk);
    #1 jif.job_valid = 1'b0;
    @(negedge clk);
    hi = 0;
    while (grid_reset && hi < 20) begin
      hi++;
      @(negedge clk);
    end
    chk("clear_len", hi, CLR);
  endtask

  task automatic wait_res(output bit stable);
    int n;
    n = 0;
    stable = 1'b1;
    while (!jif.res_valid && n < TO + 20) begin
      if (sb.size() > 0 && (grid_s1 !== sb[0].s1 || grid_s2 !== sb[0].s2))
        stable = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("res_valid_wait", jif.res_valid, 1);
  endtask

  task automatic collect(input bit stable_in);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk("res_score", jif.res_score, e.score);
    chk("res_id", jif.res_id, e.id);
    chk("res_cycles", jif.res_cycles, e.cyc);
    chk("res_timeout", jif.res_timeout, e.to);
    chk("grid_s_stable", stable_in && grid_s1 === e.s1 && grid_s2 === e.s2, 1);
    chk("done_ctl", {grid_reset, jif.job_ready, busy}, 3'b001);
    jif.res_ready = 1'b1;
    @(posedge clk);
    #1 jif.res_ready = 1'b0;
    jd_exp = (jd_exp + 1) % WRAP;
    @(negedge clk);
    chk("jobs_done", jobs_done, jd_exp);
    chk("idle_ctl", {grid_reset, jif.job_ready, jif.res_valid, busy}, 4'b1100);
  endtask

  task automatic run_job(input vec_t v);
    bit st;
    send(v);
    wait_res(st);
    collect(st);
  endtask

  vec_t vt[7];
  vec_t va;
  vec_t vb;
  logic [63:0] snap;
  int   seen;
  bit   st;

  initial begin
    vt[0] = '{8'h1B, 8'h1B, 4'd1, 5,  1'b0, 16'sd0,   16'sd4,     5,  1'b0};
    vt[1] = '{8'h00, 8'hFF, 4'd2, 8,  1'b0, 16'sd0,  -16'sd4,     8,  1'b0};
    vt[2] = '{8'h1B, 8'h4E, 4'd3, 19, 1'b1, 16'sd7,   16'sd7,     19, 1'b0};
    vt[3] = '{8'hA5, 8'h5A, 4'd4, -1, 1'b1, 16'sd99,  16'sd0,     TO, 1'b1};
    vt[4] = '{8'h33, 8'hCC, 4'd5, 49, 1'b1, -16'sd3, -16'sd3,     49, 1'b0};
    vt[5] = '{8'h0F, 8'hF0, 4'd6, 50, 1'b1, 16'sd11,  16'sd0,     TO, 1'b1};
    vt[6] = '{8'hE4, 8'h1B, 4'd7, 0,  1'b1, 16'sd32767, 16'sd32767, 0, 1'b0};

    reset         = 1'b1;
    jif.job_valid = 1'b0;
    jif.job_s1    = '0;
    jif.job_s2    = '0;
    jif.job_id    = '0;
    jif.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("idle_hold", {grid_reset, jif.job_ready, jif.res_valid, busy,
          jobs_done}, {4'b1100, CNTW'(0)});
    end

    for (int i = 0; i < 7; i++) run_job(vt[i]);

    // Back-pressure in DONE with a new job waiting.
    va = '{8'h27, 8'h72, 4'd8, 3, 1'b1, 16'sd5, 16'sd5, 3, 1'b0};
    vb = '{8'h1B, 8'h1B, 4'd9, 2, 1'b0, 16'sd0, 16'sd4, 2, 1'b0};
    send(va);
    wait_res(st);
    jif.job_s1    = vb.s1;
    jif.job_s2    = vb.s2;
    jif.job_id    = vb.id;
    jif.job_valid = 1'b1;
    snap = {jif.res_score, jif.res_id, jif.res_cycles, jif.res_timeout};
    repeat (10) begin
      @(negedge clk);
      chk("bp_stable", {jif.res_score, jif.res_id, jif.res_cycles,
          jif.res_timeout}, snap);
      chk("bp_ctl", {jif.job_ready, jif.res_valid, grid_s1}, {2'b01, va.s1});
    end
    stub_lat = vb.lat;
    stub_ovr = vb.ovr;
    collect(st);
    sb.push_back('{vb.s1, vb.s2, vb.id, vb.e_score, CNTW'(vb.e_cyc), vb.e_to});
    @(posedge clk);
    #1 jif.job_valid = 1'b0;
    @(negedge clk);
    chk("bp_accept", {busy, grid_reset, jif.job_ready, grid_s1}, {3'b110, vb.s1});
    wait_res(st);
    collect(st);

    // Reset during RUN.
    send('{8'h6C, 8'hC6, 4'd10, -1, 1'b1, 16'sd1, 16'sd0, TO, 1'b1});
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    jd_exp = 0;
    chk_reset_vals("rst_run");
    seen = 0;
    repeat (TO + 10) begin
      @(negedge clk);
      if (jif.res_valid || busy) seen++;
    end
    chk("rst_run_quiet", seen, 0);

    // Reset during DONE, with jobs_done nonzero beforehand.
    run_job('{8'h1B, 8'h1B, 4'd11, 1, 1'b1, 16'sd2, 16'sd2, 1, 1'b0});
    send('{8'h9C, 8'hC9, 4'd12, 4, 1'b1, 16'sd6, 16'sd6, 4, 1'b0});
    wait_res(st);
    chk("pre_rst_jobs", jobs_done, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    jd_exp = 0;
    chk_reset_vals("rst_done");
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (jif.res_valid || busy) seen++;
    end
    chk("rst_done_quiet", seen, 0);

    // jobs_done wrap across 2^CNTW results.
    for (int k = 0; k < WRAP; k++) begin
      vec_t vw;
      vw = '{W'(k * 37), W'(k * 91), IDW'(k), k % 3, 1'b1,
             SWD'(k - 20), SWD'(k - 20), k % 3, 1'b0};
      run_job(vw);
    end
    chk("wrap_zero", jobs_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "bench time limit");
  end

endmodule
